parity_frame_unit: RTL and testbench



---
 rtl/parity_frame_unit.sv | 126 ++++++++++++
 tb/tb_parity_frame_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_unit.sv
// Frame-level XOR parity generator/checker over FRAME_LEN beats with valid/ready on both sides.
// Optional PARITY_ERR_COUNT_EN adds a saturating check-mode error counter (err_count/err_clr).
module parity_frame_unit #(
    parameter int DATA_W    = 6,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              odd_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              out_err,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              busy
`ifdef PARITY_ERR_COUNT_EN
    ,
    input  logic              err_clr,
    output logic [7:0]        err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t           state_q;
    logic             acc_q;
    logic             mode_q;
    logic             odd_q;
    logic             out_par_q;
    logic             out_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             xfer;
    logic             res_take;
    logic             first_beat;
    logic             is_last;
    logic             eff_mode;
    logic             eff_odd;
    logic             acc_d;
    logic [CNT_W-1:0] cnt_d;

    assign in_ready  = (state_q != RESULT);
    assign out_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign out_par   = out_par_q;
    assign out_err   = out_err_q;
    assign beat_cnt  = cnt_q;

    assign xfer     = in_valid & in_ready;
    assign res_take = out_valid & out_ready;

    // The first beat uses the live mode/odd_sel, later beats the latched copies.
    // cnt_q is 0 in IDLE, so a one-beat frame is "last" on its first beat.
    assign first_beat = (state_q == IDLE);
    assign is_last    = (cnt_q == LAST_CNT);
    assign eff_mode   = first_beat ? mode    : mode_q;
    assign eff_odd    = first_beat ? odd_sel : odd_q;
    assign acc_d      = (first_beat ? 1'b0 : acc_q) ^ (^in_data);
    assign cnt_d      = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            mode_q    <= 1'b0;
            odd_q     <= 1'b0;
            out_par_q <= 1'b0;
            out_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (xfer) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (first_beat) begin
                            mode_q <= mode;
                            odd_q  <= odd_sel;
                        end
                        if (is_last) begin
                            out_par_q <= acc_d ^ eff_odd;
                            out_err_q <= eff_mode & (acc_d ^ in_par ^ eff_odd);
                            state_q   <= RESULT;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                RESULT: begin
                    if (res_take) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] err_count_q;

    assign err_count = err_count_q;

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count_q <= 8'd0;
        end else if (res_take && out_err_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_frame_unit.sv
// Self-checking bench for parity_frame_unit: table of frames via scoreboard, plus
// hand-written bubble/stall, mid-frame reset and single-beat-frame sequences.
module tb_parity_frame_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       odd_sel;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       in_par;
    logic       out_valid;
    logic       out_ready;
    logic       out_par;
    logic       out_err;
    logic [7:0] beat_cnt;
    logic       busy;

    logic       in_valid1;
    logic       in_ready1;
    logic       out_valid1;
    logic       out_ready1;
    logic       out_par1;
    logic       out_err1;
    logic [7:0] beat_cnt1;
    logic       busy1;

`ifdef PARITY_ERR_COUNT_EN
    logic       err_clr;
    logic [7:0] err_count;
    logic       err_clr1;
    logic [7:0] err_count1;
`endif

    always #5 clk = ~clk;

    parity_frame_unit #(.DATA_W(6), .FRAME_LEN(4), .CNT_W(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .odd_sel  (odd_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_par   (in_par),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_par  (out_par),
        .out_err  (out_err),
        .beat_cnt (beat_cnt),
        .busy     (busy)
`ifdef PARITY_ERR_COUNT_EN
        ,
        .err_clr  (err_clr),
        .err_count(err_count)
`endif
    );

    parity_frame_unit #(.DATA_W(6), .FRAME_LEN(1), .CNT_W(8)) u_one (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .odd_sel  (odd_sel),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .in_data  (in_data),
        .in_par   (in_par),
        .out_valid(out_valid1),
        .out_ready(out_ready1),
        .out_par  (out_par1),
        .out_err  (out_err1),
        .beat_cnt (beat_cnt1),
        .busy     (busy1)
`ifdef PARITY_ERR_COUNT_EN
        ,
        .err_clr  (err_clr1),
        .err_count(err_count1)
`endif
    );

    typedef struct {
        logic            md;
        logic            od;
        logic [3:0][5:0] b;
        logic            ip;
        logic            ep;
        logic            ee;
    } vec_t;

    typedef struct {
        logic       par;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;
    int   frame_no = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [5:0] d, input logic p);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic p, input logic e);
        exp_t x;
        x.par = p;
        x.err = e;
        x.cnt = 8'd4;
        sb.push_back(x);
    endtask

    // Wait (bounded) for a result, compare against the scoreboard head, then hand it off.
    task automatic collect(input string nm);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        chk({nm, " out_valid latency"}, 32'(out_valid), 32'd1);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({nm, " result timeout"}, 32'(out_valid), 32'd1);
        end else if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            chk({nm, " out_par"}, 32'(out_par), 32'(x.par));
            chk({nm, " out_err"}, 32'(out_err), 32'(x.err));
            chk({nm, " beat_cnt"}, 32'(beat_cnt), 32'(x.cnt));
            chk({nm, " in_ready in RESULT"}, 32'(in_ready), 32'd0);
            $display("frame %0d %s: par=%0d err=%0d cnt=%0d", frame_no, nm, out_par, out_err, beat_cnt);
        end
        frame_no++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({nm, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        chk({nm, " beat_cnt after handshake"}, 32'(beat_cnt), 32'd0);
        chk({nm, " busy after handshake"}, 32'(busy), 32'd0);
    endtask

    task automatic one_beat(input string nm, input logic md, input logic od, input logic [5:0] d,
                            input logic ip, input logic ep, input logic ee);
        mode      = md;
        odd_sel   = od;
        in_data   = d;
        in_par    = ip;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk({nm, " out_valid"}, 32'(out_valid1), 32'd1);
        chk({nm, " out_par"}, 32'(out_par1), 32'(ep));
        chk({nm, " out_err"}, 32'(out_err1), 32'(ee));
        chk({nm, " beat_cnt"}, 32'(beat_cnt1), 32'd1);
        $display("frame %0d %s: par=%0d err=%0d", frame_no, nm, out_par1, out_err1);
        frame_no++;
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        @(negedge clk);
        chk({nm, " out_valid cleared"}, 32'(out_valid1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Set A parities 1,0,1,0 -> xor 0; set B parities 1,0,1,1 -> xor 1.
        vecs[0] = '{md:1'b0, od:1'b0, b:{6'b001111, 6'b000111, 6'b000011, 6'b000001}, ip:1'b0, ep:1'b0, ee:1'b0};
        vecs[1] = '{md:1'b0, od:1'b1, b:{6'b001111, 6'b000111, 6'b000011, 6'b000001}, ip:1'b1, ep:1'b1, ee:1'b0};
        vecs[2] = '{md:1'b1, od:1'b0, b:{6'b001111, 6'b000111, 6'b000011, 6'b000001}, ip:1'b1, ep:1'b0, ee:1'b1};
        vecs[3] = '{md:1'b1, od:1'b0, b:{6'b001111, 6'b000111, 6'b000011, 6'b000001}, ip:1'b0, ep:1'b0, ee:1'b0};
        vecs[4] = '{md:1'b1, od:1'b1, b:{6'b001111, 6'b000111, 6'b000011, 6'b000001}, ip:1'b0, ep:1'b1, ee:1'b1};
        vecs[5] = '{md:1'b1, od:1'b1, b:{6'b001111, 6'b000111, 6'b000011, 6'b000001}, ip:1'b1, ep:1'b1, ee:1'b0};
        vecs[6] = '{md:1'b0, od:1'b0, b:{6'b010101, 6'b100000, 6'b000000, 6'b111110}, ip:1'b0, ep:1'b1, ee:1'b0};
        vecs[7] = '{md:1'b1, od:1'b0, b:{6'b010101, 6'b100000, 6'b000000, 6'b111110}, ip:1'b1, ep:1'b1, ee:1'b0};
        vecs[8] = '{md:1'b1, od:1'b0, b:{6'b010101, 6'b100000, 6'b000000, 6'b111110}, ip:1'b0, ep:1'b1, ee:1'b1};
        vecs[9] = '{md:1'b0, od:1'b1, b:{6'b010101, 6'b100000, 6'b000000, 6'b111110}, ip:1'b1, ep:1'b0, ee:1'b0};

        rst        = 1'b1;
        mode       = 1'b0;
        odd_sel    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 6'd0;
        in_par     = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
`ifdef PARITY_ERR_COUNT_EN
        err_clr    = 1'b0;
        err_clr1   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_par", 32'(out_par), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset beat_cnt", 32'(beat_cnt), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Table frames; mode/odd_sel and in_par are flipped on the non-sampling beats.
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) begin
                mode    = (i == 0) ? vecs[v].md : ~vecs[v].md;
                odd_sel = (i == 0) ? vecs[v].od : ~vecs[v].od;
                beat(vecs[v].b[i], (i == 3) ? vecs[v].ip : ~vecs[v].ip);
                if (i == 3) push_exp(vecs[v].ep, vecs[v].ee);
            end
            collect($sformatf("vec%0d", v));
        end
`ifdef PARITY_ERR_COUNT_EN
        @(negedge clk);
        chk("err_count after table", 32'(err_count), 32'd3);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_count cleared", 32'(err_count), 32'd0);
`endif

        // Bubble between beats 2 and 3, then a 3-cycle output stall with in_valid held high.
        mode    = 1'b0;
        odd_sel = 1'b0;
        beat(6'b000001, 1'b0);
        beat(6'b000011, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("gap beat_cnt hold", 32'(beat_cnt), 32'd2);
            chk("gap busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        beat(6'b000111, 1'b0);
        beat(6'b001111, 1'b0);
        push_exp(1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 6'b000001;
        repeat (3) begin
            @(negedge clk);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall out_par", 32'(out_par), 32'd0);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall beat_cnt", 32'(beat_cnt), 32'd4);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        collect("stall");

        // Reset after two beats of a different parity; the following frame must be clean.
        mode    = 1'b1;
        odd_sel = 1'b1;
        beat(6'b000001, 1'b0);
        beat(6'b000000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst beat_cnt", 32'(beat_cnt), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_par", 32'(out_par), 32'd0);
        @(posedge clk);
        #1;
        mode    = 1'b0;
        odd_sel = 1'b0;
        beat(6'b111110, 1'b0);
        beat(6'b000000, 1'b0);
        beat(6'b100000, 1'b0);
        beat(6'b010101, 1'b0);
        push_exp(1'b1, 1'b0);
        collect("after_rst");

        // Single-beat frames on the FRAME_LEN=1 instance.
        one_beat("len1 gen even", 1'b0, 1'b0, 6'b101100, 1'b0, 1'b1, 1'b0);
        one_beat("len1 chk even", 1'b1, 1'b0, 6'b101100, 1'b0, 1'b1, 1'b1);
        one_beat("len1 gen odd", 1'b0, 1'b1, 6'b101100, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
